aspiradora_status_tx: RTL and testbench
=======================================

# aspiradora_status_tx

Serial status reporter for the vacuum-cleaner controller. Watches the 2-bit FSM state and sends it to a host as one ASCII character in an 8N1 UART frame whenever the state changes or the host asks for it. The FSM consumes switch commands; this block is the outbound path that reports the resulting state. It sits beside the FSM inside the top-level wrapper, fed by the same clock.

## Interface

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  permits a new frame to start; never aborts a frame already started.
- state_in  input  2  FSM state: 00 power_off, 01 on, 10 cleaning, 11 evading.
- send_req  input  1  one-cycle request to report the current state even if it has not changed.
- tx  output  1  UART line, idle high.
- busy  output  1  high for every cycle of a frame (start through stop).
- frames_sent  output  8  count of completed frames; wraps from 255 to 0.

## Operation

- Character map, sent LSB first: 00 -> 0x50 'P', 01 -> 0x4F 'O', 10 -> 0x43 'C', 11 -> 0x45 'E'.
- Registers: state_q samples state_in every cycle. prev_q samples state_q every cycle. A change event is state_q != prev_q.
- pending flag: set by send_req or by a change event; cleared on the cycle a frame launches. Multiple events before a launch merge into a single frame.
- FSM states:
  - IDLE: tx=1, busy=0. If pending and ena, go to START.
  - START: latch the character for the current state_q at the moment of launch.
  - DATA: 8 bits.
  - STOP: 1 bit.
- Each of START, DATA and STOP holds every bit for exactly CLKS_PER_BIT cycles. The baud counter and bit index reset at each frame launch.
- End of stop bit:
  - frames_sent increments.
  - If pending and ena, the next START begins on the immediately following cycle, with no idle gap.
  - Otherwise the FSM returns to IDLE.
- ena low: no launch occurs and pending is retained. A frame in progress always completes.
- Events during a frame: they set pending. The follow-up frame reports the state_q value at its own launch, not the value at the time of the event.
- send_req and a change event in the same cycle produce one frame.

## Timing

- Reset values, applied immediately and asynchronously:
  - tx=1, busy=0, frames_sent=0.
  - pending=0, state_q=prev_q=00.
  - FSM in IDLE; all counters 0.
- Because state_q and prev_q reset to 00, a non-00 state_in present at reset release produces a report automatically.
- Change latency: call E0 the rising edge at which state_in is first sampled with a new value. pending is set at E1. tx falls and busy rises at E2, assuming IDLE and ena=1.
- send_req latency: send_req high at edge E0 sets pending at E0. tx falls and busy rises at E1.
- Frame length is 10*CLKS_PER_BIT cycles. busy is high for exactly these cycles and falls on the cycle after the last stop cycle, unless a back-to-back frame starts.
- frames_sent updates on the edge that ends the stop bit.
- Reset asserted mid-frame: tx returns high immediately, and the partial frame is not counted. After rst deasserts, normal operation resumes from the reset values.

## Test plan

- Reset: hold rst with state_in=00. Expect tx=1, busy=0, frames_sent=0. Release rst and wait 100 cycles: tx stays 1 and no frame is sent.
- Single change (CLKS_PER_BIT=4): state_in 00->10.
  - tx falls 2 cycles after the sampling edge.
  - Frame bits are 0, 1,1,0,0,0,0,1,0, 1 (0x43 'C'), each 4 cycles; 40 cycles total.
  - busy high for 40 cycles; frames_sent goes 0->1.
- Merge during frame: mid-frame of 'O', step state_in 01->10->11.
  - Exactly one follow-up frame, 0x45 'E', starting the cycle right after the stop bit.
  - frames_sent ends at +2.
- ena gating: with ena=0, pulse send_req with state_in=01. Expect tx to stay 1 for 50 cycles. Raise ena: one 'O' frame starts on the next edge.
- Reset mid-frame: assert rst in data bit 3 of a 'P' frame. Expect tx=1 and busy=0 at once, frames_sent=0, and no frame afterward while state_in=00.
- Counter wrap: issue 256 send_req-driven frames. frames_sent reads 255 after the 255th frame and 0 after the 256th.

Source files
------------

// File: rtl/aspiradora_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : aspiradora_status_tx
// Purpose  : Reports the vacuum-cleaner FSM state to a host as one ASCII
//            character ('P','O','C','E') in an 8N1 UART frame, sent whenever
//            the state changes or the host asks for it.
// Ports    : clk          system clock, rising edge
//            rst          asynchronous active-high reset
//            ena          permits a new frame to start (never aborts one)
//            state_in     2-bit FSM state to report
//            send_req     one-cycle request to report the current state
//            tx           UART line, idle high
//            busy         high for every cycle of a frame
//            frames_sent  count of completed frames, wraps 255 -> 0
// Revision : 1.0 - initial release
// ============================================================================
module aspiradora_status_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [1:0] state_in,
  input  logic       send_req,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frames_sent
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [7:0] state_char(input logic [1:0] s);
    case (s)
      2'b00:   state_char = 8'h50; // 'P' power_off
      2'b01:   state_char = 8'h4F; // 'O' on
      2'b10:   state_char = 8'h43; // 'C' cleaning
      default: state_char = 8'h45; // 'E' evading
    endcase
  endfunction

  tx_state_t   fsm;
  tx_state_t   fsm_d;
  logic [1:0]  state_q;
  logic [1:0]  prev_q;
  logic        pending;
  logic        change;
  logic        launch;
  logic        bit_done;
  logic [15:0] baud_cnt;
  logic [15:0] baud_cnt_d;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_d;
  logic [2:0]  bit_idx_nxt;
  logic [7:0]  char_q;
  logic [7:0]  char_d;
  logic        tx_d;
  logic        busy_d;
  logic [7:0]  frames_d;

  assign change      = (state_q != prev_q);
  assign bit_done    = (baud_cnt == BIT_LAST);
  assign bit_idx_nxt = bit_idx + 3'd1;

  // Two-stage sampling of the FSM state; a difference between the stages is
  // a one-cycle change event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 2'b00;
      prev_q  <= 2'b00;
      pending <= 1'b0;
    end else begin
      state_q <= state_in;
      prev_q  <= state_q;
      // A new event arriving on the launch cycle itself is kept, so that no
      // request is ever silently dropped.
      pending <= (pending & ~launch) | send_req | change;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm         <= ST_IDLE;
      baud_cnt    <= 16'd0;
      bit_idx     <= 3'd0;
      char_q      <= 8'd0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      frames_sent <= 8'd0;
    end else begin
      fsm         <= fsm_d;
      baud_cnt    <= baud_cnt_d;
      bit_idx     <= bit_idx_d;
      char_q      <= char_d;
      tx          <= tx_d;
      busy        <= busy_d;
      frames_sent <= frames_d;
    end
  end

  // tx and busy are computed one cycle ahead and registered, so the line is
  // glitch-free and changes exactly on the edge that enters each bit.
  always_comb begin
    fsm_d      = fsm;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    char_d     = char_q;
    tx_d       = tx;
    busy_d     = busy;
    frames_d   = frames_sent;
    launch     = 1'b0;

    case (fsm)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        launch = pending & ena;
      end
      ST_START: begin
        if (bit_done) begin
          fsm_d      = ST_DATA;
          baud_cnt_d = 16'd0;
          bit_idx_d  = 3'd0;
          tx_d       = char_q[0];
        end else begin
          baud_cnt_d = baud_cnt + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_cnt_d = 16'd0;
          if (bit_idx == 3'd7) begin
            fsm_d = ST_STOP;
            tx_d  = 1'b1;
          end else begin
            bit_idx_d = bit_idx_nxt;
            tx_d      = char_q[bit_idx_nxt];
          end
        end else begin
          baud_cnt_d = baud_cnt + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          frames_d = frames_sent + 8'd1;
          // Back-to-back: a pending report starts with no idle gap.
          launch   = pending & ena;
          if (!launch) begin
            fsm_d      = ST_IDLE;
            baud_cnt_d = 16'd0;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
          end
        end else begin
          baud_cnt_d = baud_cnt + 16'd1;
        end
      end
      default: begin
        fsm_d  = ST_IDLE;
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase

    // Character is captured from the sampled state at the launch instant, so
    // merged events always report the most recent state.
    if (launch) begin
      fsm_d      = ST_START;
      baud_cnt_d = 16'd0;
      bit_idx_d  = 3'd0;
      char_d     = state_char(state_q);
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aspiradora_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_aspiradora_status_tx
// Purpose  : Self-checking bench for aspiradora_status_tx. A waveform-level
//            reference model predicts tx/busy/frames_sent every cycle, and
//            directed vectors and sequences decode frames with a UART
//            receiver and check latencies and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aspiradora_status_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena = 1'b1;
  logic [1:0] state_in = 2'b00;
  logic       send_req = 1'b0;
  logic       tx;
  logic       busy;
  logic [7:0] frames_sent;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  aspiradora_status_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .state_in    (state_in),
    .send_req    (send_req),
    .tx          (tx),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // The model keeps a queue of the tx levels still to be driven; a frame is
  // pushed as 10*CPB line samples when it launches.
  logic [1:0] m_sq = 2'b00;
  logic [1:0] m_pq = 2'b00;
  bit         m_pend = 1'b0;
  int         m_frames = 0;
  bit         m_q[$];

  function automatic logic [7:0] char_of(input logic [1:0] s);
    logic [7:0] c;
    if (s == 2'b00)      c = "P";
    else if (s == 2'b01) c = "O";
    else if (s == 2'b10) c = "C";
    else                 c = "E";
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit launch;
    bit done;
    logic [7:0] c;
    if (rst) begin
      m_sq = 2'b00; m_pq = 2'b00; m_pend = 1'b0; m_frames = 0;
      m_q.delete();
    end else begin
      launch = m_pend && ena && (m_q.size() <= 1);
      done   = (m_q.size() == 1);
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (done) m_frames = (m_frames + 1) % 256;
      if (launch) begin
        c = char_of(m_sq);
        for (int k = 0; k < CPB; k++) m_q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int k = 0; k < CPB; k++) m_q.push_back(c[b]);
        for (int k = 0; k < CPB; k++) m_q.push_back(1'b1);
      end
      m_pend = (m_pend && !launch) || send_req || (m_sq != m_pq);
      m_pq   = m_sq;
      m_sq   = state_in;
    end
  end

  always @(negedge clk) begin
    logic e_tx;
    logic e_busy;
    if (chk_on) begin
      e_tx   = (m_q.size() > 0) ? m_q[0] : 1'b1;
      e_busy = (m_q.size() > 0);
      tests++;
      if (tx !== e_tx || busy !== e_busy || frames_sent !== 8'(m_frames)) begin
        fails++;
        $display("FAIL scoreboard t=%0t: tx/busy/frames got %b/%b/%0d expected %b/%b/%0d",
                 $time, tx, busy, frames_sent, e_tx, e_busy, m_frames);
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge where tx was first seen low (start-bit cycle 0);
  // returns at the middle of the stop bit.
  task automatic rx_frame(output logic [7:0] b, output logic stop_bit);
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    stop_bit = tx;
  endtask

  task automatic wait_fall(input int max_n, output int n);
    n = -1;
    for (int k = 1; k <= max_n; k++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        n = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0] st;
    int         req_off;  // -1: no request; else edge index sampling send_req
    logic [7:0] exp_char;
    int         exp_lat;  // edges from input change to tx low
  } vec_t;

  vec_t vecs[8];

  // ---------------------------------------------------------------- test
  initial begin
    logic [7:0] b;
    logic       sb;
    int         n;
    int         exp_frames;
    bit         stayed_high;

    vecs[0] = '{2'b10, -1, 8'h43, 3};
    vecs[1] = '{2'b10,  0, 8'h43, 2};
    vecs[2] = '{2'b01, -1, 8'h4F, 3};
    vecs[3] = '{2'b01,  0, 8'h4F, 2};
    vecs[4] = '{2'b11,  1, 8'h45, 3};
    vecs[5] = '{2'b00, -1, 8'h50, 3};
    vecs[6] = '{2'b00,  0, 8'h50, 2};
    vecs[7] = '{2'b10,  1, 8'h43, 3};

    // Reset behaviour
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_frames", frames_sent, 0);
    #2 rst = 1'b0;
    stayed_high = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) stayed_high = 1'b0;
    end
    check("reset_idle_100", stayed_high, 1);
    check("reset_idle_frames", frames_sent, 0);

    // Table-driven single reports
    exp_frames = 0;
    foreach (vecs[i]) begin
      state_in = vecs[i].st;
      send_req = (vecs[i].req_off == 0);
      n = -1;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        send_req = (vecs[i].req_off == k);
        if (tx == 1'b0) begin
          n = k;
          break;
        end
      end
      send_req = 1'b0;
      check($sformatf("vec%0d_latency", i), n, vecs[i].exp_lat);
      if (n < 0) continue;
      rx_frame(b, sb);
      check($sformatf("vec%0d_char", i), b, vecs[i].exp_char);
      check($sformatf("vec%0d_stop", i), sb, 1);
      exp_frames++;
      repeat (CPB / 2) @(negedge clk);
      check($sformatf("vec%0d_busy_end", i), busy, 0);
      check($sformatf("vec%0d_frames", i), frames_sent, exp_frames);
      repeat (10) @(negedge clk);
      check($sformatf("vec%0d_no_extra", i), frames_sent, exp_frames);
    end

    // Merge during frame: 'O' then a single back-to-back 'E'
    state_in = 2'b01;
    wait_fall(20, n);
    check("merge_first_launch", (n > 0), 1);
    repeat (10) @(negedge clk);
    state_in = 2'b10;
    repeat (4) @(negedge clk);
    state_in = 2'b11;
    repeat (10 * CPB - 14) @(negedge clk);
    check("merge_b2b_tx", tx, 0);
    check("merge_b2b_busy", busy, 1);
    rx_frame(b, sb);
    check("merge_second_char", b, 8'h45);
    exp_frames += 2;
    repeat (CPB / 2) @(negedge clk);
    check("merge_frames", frames_sent, exp_frames);
    repeat (50) @(negedge clk);
    check("merge_no_third", frames_sent, exp_frames);

    // ena gating
    ena = 1'b0;
    state_in = 2'b01;
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    stayed_high = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) stayed_high = 1'b0;
    end
    check("ena_gated_idle", stayed_high, 1);
    ena = 1'b1;
    @(negedge clk);
    check("ena_launch_next_edge", tx, 0);
    rx_frame(b, sb);
    check("ena_char", b, 8'h4F);
    exp_frames++;
    repeat (50) @(negedge clk);
    check("ena_single_frame", frames_sent, exp_frames);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ena      = ($urandom_range(0, 9) != 0);
      send_req = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 79) == 0) state_in = 2'($urandom_range(0, 3));
    end
    ena = 1'b1;
    send_req = 1'b0;
    state_in = 2'b00;
    repeat (150) @(negedge clk);

    // Reset in data bit 3 of a 'P' frame
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
    wait_fall(10, n);
    check("rstmid_launch", (n > 0), 1);
    repeat (4 * CPB + 1) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstmid_tx", tx, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_frames", frames_sent, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    stayed_high = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) stayed_high = 1'b0;
    end
    check("rstmid_no_frame", stayed_high, 1);
    check("rstmid_frames_after", frames_sent, 0);

    // Counter wrap over 256 requested frames
    for (int k = 1; k <= 256; k++) begin
      send_req = 1'b1;
      @(negedge clk);
      send_req = 1'b0;
      repeat (10 * CPB + 5) @(negedge clk);
      if (k == 255) check("wrap_255", frames_sent, 255);
      if (k == 256) check("wrap_0", frames_sent, 0);
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
